// File: rtl/bsg_cache_nb_read_miss_server.sv
// Drains an MSHR's queued read misses after refill, producing one load response per entry.
// Optional BSG_CACHE_NB_READ_MISS_SERVER_STATS_EN adds served/drain counters.
module bsg_cache_nb_read_miss_server #(
  parameter int block_size_in_words_p = 8,
  parameter int word_width_p          = 32,
  parameter int src_id_width_p        = 4,
  parameter int mshr_els_p            = 4,
  localparam int bytes_lp        = word_width_p / 8,
  localparam int lg_bytes_lp     = (bytes_lp > 1) ? $clog2(bytes_lp) : 0,
  localparam int byte_sel_w_lp   = (bytes_lp > 1) ? $clog2(bytes_lp) : 1,
  localparam int mshr_id_w_lp    = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
  localparam int word_off_w_lp   = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1,
  localparam int block_w_lp      = block_size_in_words_p * word_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      refill_v_i,
  output logic                      refill_ready_o,
  input  logic [mshr_id_w_lp-1:0]   refill_mshr_id_i,
  input  logic [block_w_lp-1:0]     refill_data_i,
  input  logic [mshr_els_p-1:0]     rmq_v_i,
  output logic                      rmq_read_v_o,
  output logic [mshr_id_w_lp-1:0]   rmq_mshr_id_o,
  input  logic [src_id_width_p-1:0] rmq_src_id_i,
  input  logic [word_off_w_lp-1:0]  rmq_word_offset_i,
  input  logic                      rmq_mask_op_i,
  input  logic [bytes_lp-1:0]       rmq_mask_i,
  input  logic [1:0]                rmq_size_op_i,
  input  logic                      rmq_sigext_op_i,
  input  logic [byte_sel_w_lp-1:0]  rmq_byte_sel_i,
  input  logic [word_width_p-1:0]   rmq_mshr_data_i,
  input  logic [bytes_lp-1:0]       rmq_mshr_data_mask_i,
  output logic                      rmq_yumi_o,
  input  logic                      rmq_read_done_i,
  output logic                      resp_v_o,
  output logic [src_id_width_p-1:0] resp_src_id_o,
  output logic [word_width_p-1:0]   resp_data_o,
  input  logic                      resp_yumi_i,
  output logic                      done_o,
  output logic [mshr_id_w_lp-1:0]   done_mshr_id_o
`ifdef BSG_CACHE_NB_READ_MISS_SERVER_STATS_EN
  , output logic [31:0]             served_count_o
  , output logic [31:0]             drain_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, SERVE, FINISH} state_e;

  state_e                    state_q, state_d;
  logic [block_w_lp-1:0]     block_q, block_d;
  logic [mshr_id_w_lp-1:0]   mshr_id_q, mshr_id_d;
  logic                      resp_v_q, resp_v_d;
  logic [src_id_width_p-1:0] resp_src_id_q, resp_src_id_d;
  logic [word_width_p-1:0]   resp_data_q, resp_data_d;

  logic [word_width_p-1:0] word, merged, shifted, sized, resp_data_n;
  int                      lg, n, base;
  logic                    sign;

  assign word = block_q[rmq_word_offset_i*word_width_p +: word_width_p];

  // Bytes already held by the MSHR are newer than the refilled block.
  always_comb begin
    merged = word;
    for (int k = 0; k < bytes_lp; k++)
      if (rmq_mshr_data_mask_i[k]) merged[8*k +: 8] = rmq_mshr_data_i[8*k +: 8];
  end

  always_comb begin
    lg = int'(rmq_size_op_i);
    if (lg > lg_bytes_lp) lg = lg_bytes_lp;
    n       = 1 << lg;
    base    = int'(rmq_byte_sel_i) & ~(n - 1);
    shifted = merged >> (8 * base);
    sign    = 1'b0;
    for (int k = 0; k < bytes_lp; k++)
      if (k == n - 1) sign = rmq_sigext_op_i & shifted[8*k+7];
    sized = '0;
    for (int k = 0; k < bytes_lp; k++)
      sized[8*k +: 8] = (k < n) ? shifted[8*k +: 8] : {8{sign}};
  end

  always_comb begin
    resp_data_n = sized;
    if (rmq_mask_op_i)
      for (int k = 0; k < bytes_lp; k++)
        resp_data_n[8*k +: 8] = rmq_mask_i[k] ? merged[8*k +: 8] : 8'h00;
  end

  always_comb begin
    state_d        = state_q;
    block_d        = block_q;
    mshr_id_d      = mshr_id_q;
    resp_v_d       = resp_v_q & ~resp_yumi_i;
    resp_src_id_d  = resp_src_id_q;
    resp_data_d    = resp_data_q;
    refill_ready_o = 1'b0;
    rmq_read_v_o   = 1'b0;
    rmq_mshr_id_o  = mshr_id_q;
    rmq_yumi_o     = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        refill_ready_o = 1'b1;
        if (refill_v_i) begin
          block_d   = refill_data_i;
          mshr_id_d = refill_mshr_id_i;
          // Never start a read on an empty queue field.
          if (rmq_v_i[refill_mshr_id_i]) begin
            rmq_read_v_o  = 1'b1;
            rmq_mshr_id_o = refill_mshr_id_i;
            state_d       = SERVE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      SERVE: begin
        if (!resp_v_q || resp_yumi_i) begin
          rmq_yumi_o    = 1'b1;
          resp_v_d      = 1'b1;
          resp_src_id_d = rmq_src_id_i;
          resp_data_d   = resp_data_n;
          if (rmq_read_done_i) state_d = FINISH;
        end
      end
      FINISH: begin
        if (!resp_v_q || resp_yumi_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      block_q       <= '0;
      mshr_id_q     <= '0;
      resp_v_q      <= 1'b0;
      resp_src_id_q <= '0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      block_q       <= block_d;
      mshr_id_q     <= mshr_id_d;
      resp_v_q      <= resp_v_d;
      resp_src_id_q <= resp_src_id_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign resp_v_o       = resp_v_q;
  assign resp_src_id_o  = resp_src_id_q;
  assign resp_data_o    = resp_data_q;
  assign done_mshr_id_o = mshr_id_q;

`ifdef BSG_CACHE_NB_READ_MISS_SERVER_STATS_EN
  logic [31:0] served_count_q, served_count_d;
  logic [31:0] drain_count_q, drain_count_d;

  always_comb begin
    served_count_d = served_count_q;
    drain_count_d  = drain_count_q + {31'b0, done_o};
    if (resp_v_q && resp_yumi_i && served_count_q != '1)
      served_count_d = served_count_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      served_count_q <= '0;
      drain_count_q  <= '0;
    end else begin
      served_count_q <= served_count_d;
      drain_count_q  <= drain_count_d;
    end
  end

  assign served_count_o = served_count_q;
  assign drain_count_o  = drain_count_q;
`endif

endmodule
